// File: rtl/bist_capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// bist_capture_sequencer_if
//
// Purpose : Host readout handshake between the BIST capture sequencer and the
//           host/scan side. The sequencer presents a capture-register index
//           together with its run index. The host accepts that pair with
//           rd_ready. The pair advances only on an edge where both rd_valid
//           and rd_ready are high.
//
// Signals :
//   rd_addr   [6:0]  capture-register index currently presented
//   rd_run    [3:0]  index of the run being read out
//   rd_valid         rd_addr / rd_run are valid
//   rd_ready         host accepts the current address
//   rd_last          final address of the final run of the campaign
//
// Modports:
//   master  - sequencer side (drives address/run/valid/last, reads ready)
//   slave   - host side (reads address/run/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface bist_capture_sequencer_if;
    logic [6:0] rd_addr;
    logic [3:0] rd_run;
    logic       rd_valid;
    logic       rd_ready;
    logic       rd_last;

    modport master (
        output rd_addr,
        output rd_run,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_addr,
        input  rd_run,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/bist_capture_sequencer.sv
// ---------------------------------------------------------------------------
// bist_capture_sequencer
//
// Purpose : Run controller for the ADPLL BIST capture block. The block runs a
//           campaign of NUM_RUNS capture runs, and each run uses a different
//           sampling offset. Each run goes through these steps:
//             1. Program the offset and the decimator.
//             2. Pulse the restart strobe for two cycles.
//             3. Wait until the capture shift registers are full.
//             4. Stream every capture-register address to the host over the
//                rd_* valid/ready handshake.
//           All outputs are registered. The block uses a single clock
//           (ref_clk_bist) and an asynchronous active-low reset.
//
// Optional feature (macro BIST_SEQ_TIMEOUT_EN):
//   When the macro is defined, a 12-bit watchdog bounds the time spent in
//   CAPTURE to TIMEOUT_CYC cycles. On expiry, the sticky timeout_err flag
//   sets and locktime_last is forced to 11'h7FF. The partial capture is
//   still read out. When the macro is undefined, CAPTURE waits
//   indefinitely and timeout_err is tied to 0.
//
// Ports:
//   ref_clk_bist         in   BIST reference clock
//   reset                in   asynchronous active-low reset
//   start                in   campaign start pulse (honoured in IDLE/DONE)
//   abort                in   return to IDLE from any state (top priority)
//   offset_base    [10:0] in  offset for run 0, sampled at start
//   decimator_cfg  [10:0] in  decimator for every run, sampled at start
//   capture_count  [6:0]  in  number of BIST registers filled
//   locktime_in    [10:0] in  BIST measured locktime
//   enable_bist          out  sampling-clock enable to the BIST block
//   new_div_ratio_given  out  BIST restart strobe (2 cycles per run)
//   offset_input   [10:0] out offset to the BIST block
//   decimator_input[10:0] out decimator to the BIST block
//   locktime_last  [10:0] out locktime sampled at the end of CAPTURE
//   busy                 out  high in any state other than IDLE and DONE
//   done                 out  high in DONE until start or abort
//   timeout_err          out  sticky capture-timeout flag
//   rd                   bist_capture_sequencer_if.master readout port
// ---------------------------------------------------------------------------
module bist_capture_sequencer #(
    parameter int REG_LEN     = 30,
    parameter int NUM_RUNS    = 4,
    parameter int OFFSET_STEP = 30,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic        ref_clk_bist,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [10:0] offset_base,
    input  logic [10:0] decimator_cfg,
    input  logic [6:0]  capture_count,
    input  logic [10:0] locktime_in,
    output logic        enable_bist,
    output logic        new_div_ratio_given,
    output logic [10:0] offset_input,
    output logic [10:0] decimator_input,
    output logic [10:0] locktime_last,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    bist_capture_sequencer_if.master rd
);

    // FSM encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_READOUT = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [6:0]  LP_REG_LEN   = 7'(REG_LEN);
    localparam logic [6:0]  LP_LAST_ADDR = 7'(REG_LEN - 1);
    localparam logic [3:0]  LP_LAST_RUN  = 4'(NUM_RUNS - 1);
    localparam logic [10:0] LP_OFS_MAX   = 11'h7FF;

    // Offset increment between runs, clamped at the 11-bit maximum so that
    // a late run never wraps around to a small offset.
    function automatic logic [10:0] sat_add_offset(input logic [10:0] a);
        logic [31:0] s;
        s = {21'd0, a} + 32'(OFFSET_STEP);
        return (s > {21'd0, LP_OFS_MAX}) ? LP_OFS_MAX : s[10:0];
    endfunction

    // Registered state and outputs
    logic [2:0]  r_state;
    logic        r_arm_cnt;
    logic [3:0]  r_run;
    logic [10:0] r_offset;
    logic [10:0] r_decimator;
    logic        r_enable;
    logic        r_strobe;
    logic [6:0]  r_addr;
    logic        r_valid;
    logic        r_last;
    logic [10:0] r_locktime;
    logic        r_busy;
    logic        r_done;

    // Next-state values
    logic [2:0]  w_state_nxt;
    logic        w_arm_cnt_nxt;
    logic [3:0]  w_run_nxt;
    logic [10:0] w_offset_nxt;
    logic [10:0] w_decimator_nxt;
    logic        w_enable_nxt;
    logic        w_strobe_nxt;
    logic [6:0]  w_addr_nxt;
    logic        w_valid_nxt;
    logic        w_last_nxt;
    logic [10:0] w_locktime_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    logic        w_cap_full;
    logic        w_to_hit;
    logic        w_final_run;
    logic        w_accept;
    logic [6:0]  w_addr_inc;

    assign w_cap_full  = (capture_count >= LP_REG_LEN);
    assign w_final_run = (r_run == LP_LAST_RUN);
    assign w_accept    = r_valid & rd.rd_ready;
    assign w_addr_inc  = r_addr + 7'd1;

`ifdef BIST_SEQ_TIMEOUT_EN
    localparam logic [11:0] LP_WD_LAST = 12'(TIMEOUT_CYC - 1);

    logic [11:0] r_wd;
    logic [11:0] w_wd_nxt;
    logic        r_timeout_err;
    logic        w_timeout_err_nxt;

    // The watchdog expires on the TIMEOUT_CYC-th CAPTURE cycle. A full
    // capture on the same cycle wins, so no error is flagged then.
    assign w_to_hit    = (r_state == S_CAPTURE) && (r_wd == LP_WD_LAST);
    assign timeout_err = r_timeout_err;
`else
    logic [11:0] w_unused_timeout;
    assign w_unused_timeout = 12'(TIMEOUT_CYC);
    assign w_to_hit         = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_arm_cnt_nxt   = r_arm_cnt;
        w_run_nxt       = r_run;
        w_offset_nxt    = r_offset;
        w_decimator_nxt = r_decimator;
        w_enable_nxt    = r_enable;
        w_strobe_nxt    = r_strobe;
        w_addr_nxt      = r_addr;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;
        w_locktime_nxt  = r_locktime;
        w_done_nxt      = r_done;
`ifdef BIST_SEQ_TIMEOUT_EN
        w_wd_nxt          = r_wd;
        w_timeout_err_nxt = r_timeout_err;
`endif

        if (abort) begin
            w_state_nxt  = S_IDLE;
            w_enable_nxt = 1'b0;
            w_strobe_nxt = 1'b0;
            w_valid_nxt  = 1'b0;
            w_last_nxt   = 1'b0;
            w_done_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Configuration is captured only here. Later changes
                        // to offset_base/decimator_cfg have no effect until
                        // the next campaign.
                        w_state_nxt     = S_ARM;
                        w_arm_cnt_nxt   = 1'b0;
                        w_run_nxt       = 4'd0;
                        w_offset_nxt    = offset_base;
                        w_decimator_nxt = decimator_cfg;
                        w_enable_nxt    = 1'b1;
                        w_strobe_nxt    = 1'b1;
                        w_done_nxt      = 1'b0;
`ifdef BIST_SEQ_TIMEOUT_EN
                        w_wd_nxt          = 12'd0;
                        w_timeout_err_nxt = 1'b0;
`endif
                    end
                end

                S_ARM: begin
                    // The strobe is held for two cycles so the BIST block sees
                    // it while its sampling clock is low.
                    if (r_arm_cnt) begin
                        w_state_nxt  = S_CAPTURE;
                        w_strobe_nxt = 1'b0;
                    end else begin
                        w_arm_cnt_nxt = 1'b1;
                    end
                end

                S_CAPTURE: begin
                    if (w_cap_full || w_to_hit) begin
                        w_locktime_nxt = w_cap_full ? locktime_in : 11'h7FF;
                        w_state_nxt    = S_READOUT;
                        // Gating the sampling clock freezes the capture contents.
                        w_enable_nxt   = 1'b0;
                        w_valid_nxt    = 1'b1;
                        w_addr_nxt     = 7'd0;
                        w_last_nxt     = (LP_LAST_ADDR == 7'd0) && w_final_run;
`ifdef BIST_SEQ_TIMEOUT_EN
                        if (!w_cap_full) begin
                            w_timeout_err_nxt = 1'b1;
                        end
`endif
                    end else begin
`ifdef BIST_SEQ_TIMEOUT_EN
                        w_wd_nxt = r_wd + 12'd1;
`endif
                    end
                end

                S_READOUT: begin
                    if (w_accept) begin
                        if (r_addr == LP_LAST_ADDR) begin
                            w_state_nxt = S_NEXT;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                        end else begin
                            w_addr_nxt = w_addr_inc;
                            w_last_nxt = (w_addr_inc == LP_LAST_ADDR) && w_final_run;
                        end
                    end
                end

                S_NEXT: begin
                    if (w_final_run) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_ARM;
                        w_arm_cnt_nxt = 1'b0;
                        w_run_nxt     = r_run + 4'd1;
                        w_offset_nxt  = sat_add_offset(r_offset);
                        w_enable_nxt  = 1'b1;
                        w_strobe_nxt  = 1'b1;
`ifdef BIST_SEQ_TIMEOUT_EN
                        w_wd_nxt = 12'd0;
`endif
                    end
                end

                default: begin
                    w_state_nxt  = S_IDLE;
                    w_enable_nxt = 1'b0;
                    w_strobe_nxt = 1'b0;
                    w_valid_nxt  = 1'b0;
                    w_last_nxt   = 1'b0;
                    w_done_nxt   = 1'b0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end

    always_ff @(posedge ref_clk_bist or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_arm_cnt   <= 1'b0;
            r_run       <= 4'd0;
            r_offset    <= 11'd0;
            r_decimator <= 11'd0;
            r_enable    <= 1'b0;
            r_strobe    <= 1'b0;
            r_addr      <= 7'd0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_locktime  <= 11'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_arm_cnt   <= w_arm_cnt_nxt;
            r_run       <= w_run_nxt;
            r_offset    <= w_offset_nxt;
            r_decimator <= w_decimator_nxt;
            r_enable    <= w_enable_nxt;
            r_strobe    <= w_strobe_nxt;
            r_addr      <= w_addr_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_locktime  <= w_locktime_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef BIST_SEQ_TIMEOUT_EN
    always_ff @(posedge ref_clk_bist or negedge reset) begin
        if (!reset) begin
            r_wd          <= 12'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd          <= w_wd_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end
`endif

    assign enable_bist         = r_enable;
    assign new_div_ratio_given = r_strobe;
    assign offset_input        = r_offset;
    assign decimator_input     = r_decimator;
    assign locktime_last       = r_locktime;
    assign busy                = r_busy;
    assign done                = r_done;

    assign rd.rd_addr  = r_addr;
    assign rd.rd_run   = r_run;
    assign rd.rd_valid = r_valid;
    assign rd.rd_last  = r_last;

endmodule

// File: tb/tb_bist_capture_sequencer.sv
module tb_bist_capture_sequencer;

    localparam int REG_LEN     = 30;
    localparam int NUM_RUNS    = 3;
    localparam int OFFSET_STEP = 30;
    localparam int TIMEOUT_CYC = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] offset_base = 11'd0;
    logic [10:0] decimator_cfg = 11'd0;
    logic [6:0]  capture_count = 7'd0;
    logic [10:0] locktime_in = 11'd0;
    logic        enable_bist;
    logic        new_div_ratio_given;
    logic [10:0] offset_input;
    logic [10:0] decimator_input;
    logic [10:0] locktime_last;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    bist_capture_sequencer_if rd_if ();

    bist_capture_sequencer #(
        .REG_LEN    (REG_LEN),
        .NUM_RUNS   (NUM_RUNS),
        .OFFSET_STEP(OFFSET_STEP),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .ref_clk_bist       (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .offset_base        (offset_base),
        .decimator_cfg      (decimator_cfg),
        .capture_count      (capture_count),
        .locktime_in        (locktime_in),
        .enable_bist        (enable_bist),
        .new_div_ratio_given(new_div_ratio_given),
        .offset_input       (offset_input),
        .decimator_input    (decimator_input),
        .locktime_last      (locktime_last),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err),
        .rd                 (rd_if)
    );

    always #5 clk = ~clk;

    // Reference: offset of run k is base + k*step, clamped at 2047.
    function automatic int exp_offset(input int base, input int k);
        int v;
        v = base + k * OFFSET_STEP;
        return (v > 2047) ? 2047 : v;
    endfunction

    function automatic logic [64:0] all_outputs();
        return {enable_bist, new_div_ratio_given, offset_input, decimator_input,
                locktime_last, busy, done, timeout_err, rd_if.rd_addr,
                rd_if.rd_run, rd_if.rd_valid, rd_if.rd_last};
    endfunction

    task automatic wait_strobe(input string tag, output bit ok);
        int tmo;
        tmo = 0;
        while (new_div_ratio_given !== 1'b1 && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        ok = (new_div_ratio_given === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s strobe_wait: got no restart strobe within 200 cycles", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b done=%b expected 0/0/0",
                     busy, rd_if.rd_valid, done);
        end
    endtask

    // One full campaign. The bench plays the BIST block and the host. It also
    // tries a start pulse and a config change mid-campaign; both must be ignored.
    task automatic test_campaign(input logic [10:0] base, input int ready_pct, input string tag);
        int          exp_q[$];
        int          accepted;
        int          run_acc;
        int          tmo;
        int          ndr_n;
        int          delay;
        int          e;
        bit          ok;
        bit          rdy;
        bit          prev_stall;
        logic [6:0]  prev_addr;
        logic [3:0]  prev_run;
        logic [10:0] dec;
        logic [10:0] lt;

        dec = 11'($urandom);
        offset_base = base;
        decimator_cfg = dec;
        accepted = 0;
        for (int k = 0; k < NUM_RUNS; k++)
            for (int a = 0; a < REG_LEN; a++)
                exp_q.push_back(k * 128 + a);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int k = 0; k < NUM_RUNS; k++) begin
            wait_strobe(tag, ok);
            if (!ok) return;
            checks++;
            if (offset_input !== 11'(exp_offset(int'(base), k))) begin
                errors++;
                $display("FAIL %s offset run%0d: got %0d expected %0d", tag, k,
                         offset_input, exp_offset(int'(base), k));
            end
            checks++;
            if (decimator_input !== dec || enable_bist !== 1'b1) begin
                errors++;
                $display("FAIL %s arm run%0d: got dec=%0d en=%b expected dec=%0d en=1",
                         tag, k, decimator_input, enable_bist, dec);
            end
            capture_count = 7'd0;
            lt = 11'($urandom);
            locktime_in = lt;
            if (k == 0) begin
                offset_base = ~base;
                decimator_cfg = ~dec;
                start = 1'b1;
            end
            ndr_n = 0;
            while (new_div_ratio_given === 1'b1 && ndr_n < 5) begin
                ndr_n++;
                @(negedge clk);
                start = 1'b0;
            end
            checks++;
            if (ndr_n != 2 || enable_bist !== 1'b1) begin
                errors++;
                $display("FAIL %s strobe_len run%0d: got %0d cycles en=%b expected 2 cycles en=1",
                         tag, k, ndr_n, enable_bist);
            end
            delay = $urandom_range(0, 12);
            if (delay == 0) begin
                capture_count = 7'($urandom_range(REG_LEN, 127));
            end else begin
                repeat (delay) @(negedge clk);
                capture_count = 7'(REG_LEN);
            end
            tmo = 0;
            while (rd_if.rd_valid !== 1'b1 && tmo < 50) begin
                @(negedge clk);
                tmo++;
            end
            checks++;
            if (rd_if.rd_valid !== 1'b1 || locktime_last !== lt || enable_bist !== 1'b0 ||
                rd_if.rd_run !== 4'(k)) begin
                errors++;
                $display("FAIL %s readout_entry run%0d: got valid=%b lock=%0d en=%b run=%0d expected 1/%0d/0/%0d",
                         tag, k, rd_if.rd_valid, locktime_last, enable_bist, rd_if.rd_run, lt, k);
                return;
            end

            run_acc = 0;
            prev_stall = 1'b0;
            prev_addr = '0;
            prev_run = '0;
            tmo = 0;
            while (run_acc < REG_LEN && tmo < 2000) begin
                if (rd_if.rd_valid === 1'b1) begin
                    if (prev_stall) begin
                        checks++;
                        if (rd_if.rd_addr !== prev_addr || rd_if.rd_run !== prev_run) begin
                            errors++;
                            $display("FAIL %s hold: got addr=%0d run=%0d expected addr=%0d run=%0d",
                                     tag, rd_if.rd_addr, rd_if.rd_run, prev_addr, prev_run);
                        end
                    end
                    rdy = ($urandom_range(0, 99) < ready_pct);
                    rd_if.rd_ready = rdy;
                    if (rdy) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (rd_if.rd_run !== 4'(e / 128) || rd_if.rd_addr !== 7'(e % 128) ||
                            rd_if.rd_last !== (exp_q.size() == 0)) begin
                            errors++;
                            $display("FAIL %s accept: got run=%0d addr=%0d last=%b expected run=%0d addr=%0d last=%b",
                                     tag, rd_if.rd_run, rd_if.rd_addr, rd_if.rd_last,
                                     e / 128, e % 128, exp_q.size() == 0);
                        end
                        accepted++;
                        run_acc++;
                    end
                    prev_stall = !rdy;
                    prev_addr = rd_if.rd_addr;
                    prev_run = rd_if.rd_run;
                end else begin
                    rd_if.rd_ready = 1'b0;
                    prev_stall = 1'b0;
                end
                @(negedge clk);
                tmo++;
            end
            rd_if.rd_ready = 1'b0;
        end

        tmo = 0;
        while (done !== 1'b1 && tmo < 10) begin
            @(negedge clk);
            tmo++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_if.rd_valid !== 1'b0 ||
            accepted != NUM_RUNS * REG_LEN) begin
            errors++;
            $display("FAIL %s done: got done=%b busy=%b valid=%b accepted=%0d expected 1/0/0/%0d",
                     tag, done, busy, rd_if.rd_valid, accepted, NUM_RUNS * REG_LEN);
        end
        capture_count = 7'd0;
    endtask

    task automatic test_abort();
        logic [10:0] base;
        logic [10:0] base2;
        int          tmo;
        bit          ok;
        base = 11'($urandom_range(0, 1500));
        base2 = 11'($urandom_range(0, 1500));
        offset_base = base;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobe("abort", ok);
        if (!ok) return;
        capture_count = 7'(REG_LEN);
        rd_if.rd_ready = 1'b1;
        tmo = 0;
        while (!(rd_if.rd_valid === 1'b1 && rd_if.rd_addr == 7'd12) && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rd_if.rd_ready = 1'b0;
        capture_count = 7'd0;
        checks++;
        if (rd_if.rd_valid !== 1'b0 || busy !== 1'b0 || enable_bist !== 1'b0 ||
            new_div_ratio_given !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_readout: got valid=%b busy=%b en=%b strobe=%b done=%b expected all 0",
                     rd_if.rd_valid, busy, enable_bist, new_div_ratio_given, done);
        end
        offset_base = base2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobe("abort_restart", ok);
        if (!ok) return;
        checks++;
        if (offset_input !== base2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got offset=%0d busy=%b expected %0d/1",
                     offset_input, busy, base2);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || enable_bist !== 1'b0) begin
            errors++;
            $display("FAIL abort_arm: got busy=%b en=%b expected 0/0", busy, enable_bist);
        end
    endtask

    task automatic test_timeout();
        int tmo;
        int n;
        bit ok;
        capture_count = 7'd0;
        offset_base = 11'd100;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobe("timeout", ok);
        if (!ok) return;
        tmo = 0;
        while (new_div_ratio_given === 1'b1 && tmo < 5) begin
            @(negedge clk);
            tmo++;
        end
`ifdef BIST_SEQ_TIMEOUT_EN
        n = 0;
        while (rd_if.rd_valid !== 1'b1 && n < TIMEOUT_CYC + 20) begin
            if (n == TIMEOUT_CYC - 1) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: got err=%b expected 0", timeout_err);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TIMEOUT_CYC || timeout_err !== 1'b1 || locktime_last !== 11'h7FF ||
            rd_if.rd_addr !== 7'd0 || enable_bist !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got cycles=%0d err=%b lock=%0d addr=%0d en=%b expected %0d/1/2047/0/0",
                     n, timeout_err, locktime_last, rd_if.rd_addr, enable_bist, TIMEOUT_CYC);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b busy=%b expected 1/0", timeout_err, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b expected 0", timeout_err);
        end
`else
        n = 0;
        while (n < TIMEOUT_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_if.rd_valid !== 1'b0 || timeout_err !== 1'b0 || enable_bist !== 1'b1 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: got valid=%b err=%b en=%b busy=%b expected 0/0/1/1",
                     rd_if.rd_valid, timeout_err, enable_bist, busy);
        end
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_capture();
        logic [10:0] base;
        bit          ok;
        base = 11'($urandom_range(0, 2047));
        capture_count = 7'd0;
        offset_base = 11'd77;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobe("reset_mid", ok);
        if (!ok) return;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || enable_bist !== 1'b1 || new_div_ratio_given !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pre: got busy=%b en=%b strobe=%b expected 1/1/0",
                     busy, enable_bist, new_div_ratio_given);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected 0", all_outputs());
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || enable_bist !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got busy=%b en=%b expected 0/0", busy, enable_bist);
        end
        offset_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobe("reset_mid_restart", ok);
        if (!ok) return;
        checks++;
        if (offset_input !== base) begin
            errors++;
            $display("FAIL reset_mid_restart: got offset=%0d expected %0d", offset_input, base);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        test_reset();
        test_campaign(11'd5, 100, "plan_basic");
        test_campaign(11'($urandom_range(0, 2047)), 50, "random_ready");
        test_campaign(11'd2040, 60, "saturate");
        test_campaign(11'($urandom_range(0, 1000)), 30, "back_to_back");
        test_abort();
        test_timeout();
        test_reset_mid_capture();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
